mem_arbiter: RTL

- Owns the single byte-wide RAM port; shares it between instruction fetch (IF) and the load/store stage (MEM).
- Sequences each request into byte-serial RAM cycles and assembles or splits 32-bit words.
- Returns a one-cycle done pulse per transfer; the stall controller turns pending/not-done into stall bits.
- Aborts in-flight fetches when EX redirects the PC.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W      = 3;

  localparam logic [31:0] IO_ADDR_0_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_1_DEF = 32'h0003_0004;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  // Number of RAM byte cycles for a MEM access; the reserved code 11 is a word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = CNT_W'(1);
      LEN_H:   len_bytes = CNT_W'(2);
      LEN_W:   len_bytes = CNT_W'(4);
      default: len_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// load/store stage, serialising 8/16/32-bit transfers into byte cycles.
// Optional macro MEM_ARBITER_IO_STALL_EN holds stores to the two UART
// addresses while io_buffer_full_in is high.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] IO_ADDR_0 = ADDR_W'(IO_ADDR_0_DEF),
  parameter logic [ADDR_W-1:0] IO_ADDR_1 = ADDR_W'(IO_ADDR_1_DEF)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  input  logic              io_buffer_full_in
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        if_inst_q, if_inst_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic [7:0]         dout_q, dout_d;
  logic               wr_q, wr_d;
  logic               if_done_q, if_done_d;
  logic               mem_done_q, mem_done_d;

  logic               mem_grant_c, if_grant_c, io_hold_c;
  logic [CNT_W-1:0]   nbytes_c;
  logic [1:0]         rd_idx_c, wr_idx_c;
  logic [31:0]        asm_c;
  logic               last_rd_c, last_wr_c;

  // Grant decode: MEM wins, a just-finished requester sits out one cycle.
  assign mem_grant_c = (state_q == IDLE) && mem_req_in && !mem_done_q;
  assign if_grant_c  = (state_q == IDLE) && if_req_in && !if_done_q && !flush_in && !mem_grant_c;

  assign nbytes_c  = (state_q == IF_RD) ? CNT_W'(4) : len_bytes(mem_len_in);
  assign rd_idx_c  = 2'(cnt_q - CNT_W'(1));
  assign wr_idx_c  = 2'(cnt_q + CNT_W'(1));
  assign last_rd_c = (cnt_q == nbytes_c);
  assign last_wr_c = !((cnt_q + CNT_W'(1)) < nbytes_c);

  // Word being assembled with the byte arriving this cycle merged in.
  always_comb begin
    asm_c = buf_q;
    asm_c[{rd_idx_c, 3'b000} +: 8] = ram_din_in;
  end

`ifdef MEM_ARBITER_IO_STALL_EN
  assign io_hold_c = (state_q == MEM_WR) && io_buffer_full_in &&
                     ((addr_q == IO_ADDR_0) || (addr_q == IO_ADDR_1));
`else
  logic unused_io;
  assign unused_io = io_buffer_full_in ^ (^IO_ADDR_0) ^ (^IO_ADDR_1);
  assign io_hold_c = 1'b0;
`endif

  // State and datapath registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_grant_c)     state_d = mem_we_in ? MEM_WR : MEM_RD;
        else if (if_grant_c) state_d = IF_RD;
      end
      IF_RD:   if (flush_in || last_rd_c) state_d = IDLE;
      MEM_RD:  if (last_rd_c) state_d = IDLE;
      MEM_WR:  if (!io_hold_c && last_wr_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the counter, RAM port and result registers.
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_grant_c) begin
          cnt_d  = '0;
          buf_d  = '0;
          addr_d = mem_addr_in;
          wr_d   = mem_we_in;
          dout_d = mem_wdata_in[7:0];
        end else if (if_grant_c) begin
          cnt_d  = '0;
          buf_d  = '0;
          addr_d = if_addr_in;
          wr_d   = 1'b0;
        end
      end
      IF_RD, MEM_RD: begin
        if ((state_q == IF_RD) && flush_in) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != '0) buf_d = asm_c;
          if ((cnt_q + CNT_W'(1)) < nbytes_c) addr_d = addr_q + ADDR_W'(1);
          if (last_rd_c) begin
            cnt_d = '0;
            if (state_q == IF_RD) begin
              if_inst_d = asm_c;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = asm_c;
              mem_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MEM_WR: begin
        if (!io_hold_c) begin
          if (last_wr_c) begin
            cnt_d      = '0;
            wr_d       = 1'b0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            dout_d = mem_wdata_in[{wr_idx_c, 3'b000} +: 8];
            wr_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ram_a_out     = addr_q;
  assign ram_dout_out  = dout_q;
  assign ram_wr_out    = wr_q & rdy_in & ~io_hold_c;
  assign if_done_out   = if_done_q;
  assign if_inst_out   = if_inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;

endmodule
